// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//   Bitstream loader for the fabric scan chains. Config words arrive on a
//   valid/ready stream and are shifted LSB first into the CLB chain, then
//   into the connection chain. The fabric is held in reset until the whole
//   load has completed.
//
//   Optional feature: define CFG_CRC_EN to add a CRC-8 (poly 0x07, init 0)
//   over every shifted chain bit. The CRC is checked against one trailing
//   word after the connection chain. Without the macro there is no CRC logic
//   and cfg_error is tied low.
//
// Ports
//   scan_clk      in   single clock for config logic and chains
//   reset         in   asynchronous, active-high
//   cfg_start     in   pulse, begins a load (honoured in IDLE/DONE/ERR)
//   cfg_valid     in   cfg_data valid
//   cfg_data      in   config word, bit 0 shifted first
//   cfg_ready     out  word accepted this cycle (decoded from state)
//   clb_scan_en   out  CLB chain shift enable
//   clb_scan_in   out  CLB chain serial data
//   conn_scan_en  out  connection chain shift enable
//   conn_scan_in  out  connection chain serial data
//   fabric_reset  out  high until the load completes successfully
//   cfg_busy      out  load in progress
//   cfg_done      out  load completed OK (level)
//   cfg_error     out  CRC mismatch (level, CRC build only)
module fpga_cfg_loader #(
  parameter int CLB_CHAIN_LEN  = 1024,
  parameter int CONN_CHAIN_LEN = 4096,
  parameter int WORD_W         = 8
) (
  input  logic              scan_clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              clb_scan_en,
  output logic              clb_scan_in,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  output logic              fabric_reset,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int MAX_LEN = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN : CONN_CHAIN_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(WORD_W);

  localparam logic [CNT_W-1:0] CLB_LAST  = CNT_W'(CLB_CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CONN_LAST = CNT_W'(CONN_CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_CHECK,
    S_CRC,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              chain_q, chain_d;     // 0: CLB chain, 1: connection chain
  logic [CNT_W-1:0]  cnt_q, cnt_d;         // bits shifted into the active chain
  logic [IDX_W-1:0]  idx_q, idx_d;         // next bit of the latched word
  logic [WORD_W-1:0] word_q, word_d;
  logic              clb_en_q, clb_en_d;
  logic              clb_in_q, clb_in_d;
  logic              conn_en_q, conn_en_d;
  logic              conn_in_q, conn_in_d;
  logic              fab_rst_q, fab_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              shift_bit;

`ifdef CFG_CRC_EN
  logic [7:0]        crc_q, crc_d;
  logic              err_q, err_d;
`endif

  assign shift_bit = word_q[idx_q];

  always_comb begin
    state_d   = state_q;
    chain_d   = chain_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    clb_en_d  = 1'b0;
    clb_in_d  = 1'b0;
    conn_en_d = 1'b0;
    conn_in_d = 1'b0;
`ifdef CFG_CRC_EN
    crc_d     = crc_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (cfg_start) begin
          state_d = S_FETCH;
          chain_d = 1'b0;
          cnt_d   = '0;
`ifdef CFG_CRC_EN
          crc_d   = 8'h00;
`endif
        end
      end

      S_FETCH: begin
        if (cfg_valid) begin
          word_d  = cfg_data;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (!chain_q) begin
          clb_en_d = 1'b1;
          clb_in_d = shift_bit;
        end else begin
          conn_en_d = 1'b1;
          conn_in_d = shift_bit;
        end
`ifdef CFG_CRC_EN
        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shift_bit) ? 8'h07 : 8'h00);
`endif
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q + 1'b1;
        // Chain end takes priority over word end: leftover high bits of a
        // chain's final word are dropped, and the next chain starts on a
        // fresh word.
        if (!chain_q && (cnt_q == CLB_LAST)) begin
          chain_d = 1'b1;
          cnt_d   = '0;
          state_d = S_FETCH;
        end else if (chain_q && (cnt_q == CONN_LAST)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_FETCH;
        end
      end

      S_CHECK: begin
`ifdef CFG_CRC_EN
        state_d = S_CRC;
`else
        state_d = S_DONE;
`endif
      end

`ifdef CFG_CRC_EN
      S_CRC: begin
        if (cfg_valid) begin
          state_d = (cfg_data[7:0] == crc_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered, so
    // they line up with the state register rather than lagging it.
    busy_d    = (state_d == S_FETCH) || (state_d == S_SHIFT) ||
                (state_d == S_CHECK) || (state_d == S_CRC);
    done_d    = (state_d == S_DONE);
    fab_rst_d = (state_d != S_DONE);
`ifdef CFG_CRC_EN
    err_d     = (state_d == S_ERR);
`endif
  end

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      chain_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      clb_en_q  <= 1'b0;
      clb_in_q  <= 1'b0;
      conn_en_q <= 1'b0;
      conn_in_q <= 1'b0;
      fab_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_CRC_EN
      crc_q     <= 8'h00;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      clb_en_q  <= clb_en_d;
      clb_in_q  <= clb_in_d;
      conn_en_q <= conn_en_d;
      conn_in_q <= conn_in_d;
      fab_rst_q <= fab_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_CRC_EN
      crc_q     <= crc_d;
      err_q     <= err_d;
`endif
    end
  end

  // The CRC word is fetched through its own state, so it also raises ready.
  assign cfg_ready    = (state_q == S_FETCH) || (state_q == S_CRC);
  assign clb_scan_en  = clb_en_q;
  assign clb_scan_in  = clb_in_q;
  assign conn_scan_en = conn_en_q;
  assign conn_scan_in = conn_in_q;
  assign fabric_reset = fab_rst_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
`ifdef CFG_CRC_EN
  assign cfg_error    = err_q;
`else
  assign cfg_error    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Testbench for fpga_cfg_loader. DUT 0 uses CLB=10/CONN=5, DUT 1 uses
// CLB=16/CONN=5; both use 8-bit words and share the stream inputs, each with
// its own start. A monitor records every enabled scan bit per chain, and each
// load is compared with table constants or with a reference model that
// derives chain bit i straight from word i/8, bit i%8.
module tb_fpga_cfg_loader;

  logic       scan_clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_start = 1'b0;
  logic       start2 = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;

  logic cfg_ready, clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in;
  logic fabric_reset, cfg_busy, cfg_done, cfg_error;
  logic rdy2, clb_en2, clb_in2, conn_en2, conn_in2, fab2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  bit clb_hist  [2][4096];
  bit conn_hist [2][4096];
  int clb_n  [2] = '{0, 0};
  int conn_n [2] = '{0, 0};
  bit ovl = 1'b0;

  always #5 scan_clk = ~scan_clk;

  fpga_cfg_loader #(.CLB_CHAIN_LEN(10), .CONN_CHAIN_LEN(5), .WORD_W(8)) dut0 (
    .scan_clk(scan_clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in),
    .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in),
    .fabric_reset(fabric_reset), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  fpga_cfg_loader #(.CLB_CHAIN_LEN(16), .CONN_CHAIN_LEN(5), .WORD_W(8)) dut1 (
    .scan_clk(scan_clk), .reset(reset), .cfg_start(start2),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(rdy2),
    .clb_scan_en(clb_en2), .clb_scan_in(clb_in2),
    .conn_scan_en(conn_en2), .conn_scan_in(conn_in2),
    .fabric_reset(fab2), .cfg_busy(busy2),
    .cfg_done(done2), .cfg_error(err2)
  );

  // Scan monitor: registered outputs are sampled on the falling edge.
  always @(negedge scan_clk) begin
    if (clb_scan_en) begin
      if (clb_n[0] < 4096) clb_hist[0][clb_n[0]] = clb_scan_in;
      clb_n[0] = clb_n[0] + 1;
    end
    if (conn_scan_en) begin
      if (conn_n[0] < 4096) conn_hist[0][conn_n[0]] = conn_scan_in;
      conn_n[0] = conn_n[0] + 1;
    end
    if (clb_en2) begin
      if (clb_n[1] < 4096) clb_hist[1][clb_n[1]] = clb_in2;
      clb_n[1] = clb_n[1] + 1;
    end
    if (conn_en2) begin
      if (conn_n[1] < 4096) conn_hist[1][conn_n[1]] = conn_in2;
      conn_n[1] = conn_n[1] + 1;
    end
    if ((clb_scan_en && conn_scan_en) || (clb_en2 && conn_en2)) ovl = 1'b1;
  end

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    bit          poke;
    logic [15:0] eclb;
    logic [7:0]  econn;
  } vec_t;

  task automatic tick;
    @(negedge scan_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_of(logic [63:0] a, int na, logic [63:0] b, int nb);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < na; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ a[i]) ? 8'h07 : 8'h00);
    for (int i = 0; i < nb; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  // Reference: chain bit i lives in word (first_word + i/8), bit i%8.
  task automatic model(input logic [7:0] w[8], input int lc, input int ln,
                       output logic [63:0] eclb, output logic [63:0] econn);
    int cw;
    cw = (lc + 7) / 8;
    eclb = '0;
    econn = '0;
    for (int i = 0; i < lc; i++) eclb[i] = w[i / 8][i % 8];
    for (int j = 0; j < ln; j++) econn[j] = w[cw + j / 8][j % 8];
  endtask

  task automatic send_word(input string name, input logic [7:0] w, input int gap, input int sel);
    int n;
    cfg_valid = 1'b0;
    repeat (gap) tick;
    cfg_valid = 1'b1;
    cfg_data  = w;
    n = 0;
    while (!((sel == 0) ? cfg_ready : rdy2) && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk({name, "_ready_timeout"}, 64'(n), 64'(0));
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [7:0] w[8], input int gap,
                         input bit poke, input int sel, input logic [7:0] crc_xor,
                         input logic [63:0] eclb, input logic [63:0] econn);
    int lc, ln, nw, cb, nb, n, g, gc, gn;
    logic [63:0] got_clb, got_conn;
    logic [7:0]  crc;
    lc = (sel == 0) ? 10 : 16;
    ln = 5;
    nw = (lc + 7) / 8 + (ln + 7) / 8;
    cb = clb_n[sel];
    nb = conn_n[sel];
    if (sel == 0) cfg_start = 1'b1; else start2 = 1'b1;
    tick;
    cfg_start = 1'b0;
    start2    = 1'b0;
    for (int i = 0; i < nw; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      send_word(name, w[i], g, sel);
      if (poke && i == 0) begin
        // start during the CLB shift must be ignored
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
      end
    end
    crc = crc_of(eclb, lc, econn, ln);
`ifdef CFG_CRC_EN
    send_word(name, crc ^ crc_xor, gap < 0 ? 1 : gap, sel);
`endif
    n = 0;
    while (!((sel == 0) ? (cfg_done | cfg_error) : (done2 | err2)) && n < 200) begin
      tick;
      n++;
    end
    chk({name, "_finish_in_time"}, 64'(n < 200), 64'(1));
    gc = clb_n[sel] - cb;
    gn = conn_n[sel] - nb;
    got_clb  = '0;
    got_conn = '0;
    for (int k = 0; k < gc && k < 64; k++) got_clb[k]  = clb_hist[sel][(cb + k) % 4096];
    for (int k = 0; k < gn && k < 64; k++) got_conn[k] = conn_hist[sel][(nb + k) % 4096];
    $display("load %s dut=%0d clb=%0h/%0d conn=%0h/%0d crc=%0h", name, sel,
             got_clb, gc, got_conn, gn, crc);
    chk({name, "_clb_bits"},  got_clb,  eclb);
    chk({name, "_clb_count"}, 64'(gc),  64'(lc));
    chk({name, "_conn_bits"}, got_conn, econn);
    chk({name, "_conn_count"}, 64'(gn), 64'(ln));
    chk({name, "_busy"}, (sel == 0) ? cfg_busy : busy2, 1'b0);
    if (crc_xor == 8'h00) begin
      chk({name, "_done"},  (sel == 0) ? cfg_done : done2, 1'b1);
      chk({name, "_fabric_reset"}, (sel == 0) ? fabric_reset : fab2, 1'b0);
      chk({name, "_error"}, (sel == 0) ? cfg_error : err2, 1'b0);
    end else begin
      chk({name, "_done"},  (sel == 0) ? cfg_done : done2, 1'b0);
      chk({name, "_fabric_reset"}, (sel == 0) ? fabric_reset : fab2, 1'b1);
      chk({name, "_error"}, (sel == 0) ? cfg_error : err2, 1'b1);
    end
  endtask

  initial begin
    vec_t        tbl [4];
    logic [7:0]  w [8];
    logic [63:0] eclb, econn;
    int          cb, n;

    tbl[0] = '{w0: 8'h35, w1: 8'h02, w2: 8'h1A, gap: 0, poke: 1'b0, eclb: 16'h0235, econn: 8'h1A};
    tbl[1] = '{w0: 8'h35, w1: 8'h02, w2: 8'h1A, gap: 5, poke: 1'b0, eclb: 16'h0235, econn: 8'h1A};
    tbl[2] = '{w0: 8'h35, w1: 8'h02, w2: 8'h1A, gap: 0, poke: 1'b1, eclb: 16'h0235, econn: 8'h1A};
    tbl[3] = '{w0: 8'hA5, w1: 8'h03, w2: 8'h15, gap: 2, poke: 1'b0, eclb: 16'h03A5, econn: 8'h15};
    for (int i = 0; i < 8; i++) w[i] = 8'h00;

    #1 reset = 1'b1;
    #12;
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_scan", {clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in}, 4'b0000);
    chk("rst_fabric_reset", fabric_reset, 1'b1);
    chk("rst_status", {cfg_busy, cfg_done, cfg_error}, 3'b000);
    chk("rst_dut1", {rdy2, clb_en2, conn_en2, fab2, busy2, done2, err2}, 7'b0001000);
    tick;
    reset = 1'b0;
    tick;

    // Table vectors: back-to-back, gapped, start poked mid-shift, other data
    for (int t = 0; t < 4; t++) begin
      w[0] = tbl[t].w0; w[1] = tbl[t].w1; w[2] = tbl[t].w2;
      do_load($sformatf("vec%0d", t), w, tbl[t].gap, tbl[t].poke, 0, 8'h00,
              64'(tbl[t].eclb), 64'(tbl[t].econn));
    end

    // Start while in DONE: next cycle back in reset/busy, done cleared
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("restart_fabric_reset", fabric_reset, 1'b1);
    chk("restart_done", cfg_done, 1'b0);
    chk("restart_busy", cfg_busy, 1'b1);
    chk("restart_ready", cfg_ready, 1'b1);

    // Reset after 4 CLB bits, then a full reload
    w[0] = 8'h35; w[1] = 8'h02; w[2] = 8'h1A;
    cb = clb_n[0];
    send_word("midrst", 8'h35, 0, 0);
    n = 0;
    while ((clb_n[0] - cb) < 4 && n < 50) begin
      tick;
      n++;
    end
    chk("midrst_four_bits", 64'(clb_n[0] - cb), 64'(4));
    reset = 1'b1;
    #1;
    chk("midrst_scan", {clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in}, 4'b0000);
    chk("midrst_fabric_reset", fabric_reset, 1'b1);
    chk("midrst_status", {cfg_ready, cfg_busy, cfg_done, cfg_error}, 4'b0000);
    tick;
    reset = 1'b0;
    tick;
    do_load("after_rst", w, 0, 1'b0, 0, 8'h00, 64'h235, 64'h1A);

    // Randomized loads against the reference model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
      model(w, 10, 5, eclb, econn);
      do_load($sformatf("rnd%0d", r), w, -1, 1'b0, 0, 8'h00, eclb, econn);
    end

`ifdef CFG_CRC_EN
    // Wrong CRC word -> ERR, then a good load recovers from ERR
    w[0] = 8'h35; w[1] = 8'h02; w[2] = 8'h1A;
    do_load("crc_bad", w, 0, 1'b0, 0, 8'h01, 64'h235, 64'h1A);
    do_load("crc_recover", w, 0, 1'b0, 0, 8'h00, 64'h235, 64'h1A);
`endif

    // 16-bit CLB chain: two full words, no padding skip, then CONN
    w[0] = 8'hFF; w[1] = 8'h00; w[2] = 8'h1A;
    do_load("clb16", w, 0, 1'b0, 1, 8'h00, 64'h00FF, 64'h1A);
    w[0] = 8'h5C; w[1] = 8'hC3; w[2] = 8'h0E;
    model(w, 16, 5, eclb, econn);
    do_load("clb16_rnd", w, -1, 1'b0, 1, 8'h00, eclb, econn);

    chk("en_exclusive", ovl, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
